mod12_run_ctrl: RTL

Run controller that sequences a mod-12 counter datapath for a programmed number of full revolutions (0..11 then back to 0).
- Owns the counter enable; supports start, pause and stop.
- Reports wraps, completed revolutions, busy and done.
- Sits between control logic and the counter, replacing a free-running enable with a counted, interruptible run.

---
 rtl/mod12_ctrl_pkg.sv | 20 ++
 rtl/mod_n_counter.sv | 34 +++
 rtl/mod12_run_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/mod12_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod12_ctrl_pkg : shared state encoding and defaults for run ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mod12_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_MOD   = 12;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_REV_W = 8;

endpackage
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod_n_counter : enabled modulo-MOD up counter with sync clear      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mod_n_counter #(
  parameter int MOD   = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count_out,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MOD - 1);

  // Explicit compare against MOD-1 so non-power-of-two moduli never overflow
  assign at_max = (count_out == MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
    end else if (clr) begin
      count_out <= '0;
    end else if (en) begin
      count_out <= at_max ? '0 : count_out + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod12_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod12_run_ctrl : counted, pausable run control for a mod-N counter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mod12_run_ctrl
  import mod12_ctrl_pkg::*;
#(
  parameter int MOD   = DEF_MOD,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REV_W = DEF_REV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [REV_W-1:0] cycles,
  output logic             in_en,
  output logic [CNT_W-1:0] count_out,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [REV_W-1:0] target;
  logic [REV_W-1:0] rev_inc;
  logic             at_max;
  logic             wrap_evt;
  logic             cnt_clr;
  logic             start_acc;

  assign in_en     = (state == RUN) & ~pause & ~stop;
  assign wrap_evt  = in_en & at_max;
  assign rev_inc   = rev_cnt + REV_W'(1);
  assign start_acc = (state == IDLE) & start;
  assign busy      = (state == RUN) | (state == PAUSE);
  assign done      = (state == DONE);

  mod_n_counter #(
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (in_en),
    .clr       (cnt_clr),
    .count_out (count_out),
    .at_max    (at_max)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          state_nxt = (cycles != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (wrap_evt && (rev_inc == target)) begin
          state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (!pause) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rev_cnt survives a stop so the caller can see how far the run got
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      target  <= '0;
      rev_cnt <= '0;
      wrap    <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= wrap_evt;
      if (start_acc) begin
        target  <= cycles;
        rev_cnt <= '0;
      end else if (wrap_evt) begin
        rev_cnt <= rev_inc;
      end
    end
  end

endmodule
`default_nettype wire
